// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART receive deserializer (1 start, WIDTH data bits LSB first, 1 stop).
// Define UART_RX_DESER_PARITY_EN to insert an even-parity bit ahead of the stop bit.
module uart_rx_deser #(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_TOP = CW'(CPB - 1);
    localparam logic [CW-1:0] C_MID = CW'(HALF - 1);
    localparam logic [BW-1:0] B_TOP = BW'(WIDTH - 1);

    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx_deser: CLK_FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_sync;
    logic             r_rx_d;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_shift;
    logic             w_rx_s, w_tick, w_mid, w_last, w_stop_smp;
    logic             w_dv_set, w_fe_set, w_pe_set;
`ifdef UART_RX_DESER_PARITY_EN
    logic             r_par_bad;
`endif

    assign w_rx_s     = r_sync[1];
    assign w_tick     = r_cnt == C_TOP;
    assign w_mid      = r_cnt == C_MID;
    assign w_last     = w_tick && r_bit == B_TOP;
    assign w_stop_smp = r_state == STOP && w_tick;
    assign busy       = r_state != IDLE;

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_rx_d && !w_rx_s) w_state_nxt = START;
            START:   if (w_mid) w_state_nxt = w_rx_s ? IDLE : DATA;
`ifdef UART_RX_DESER_PARITY_EN
            DATA:    if (w_last) w_state_nxt = PARITY;
            PARITY:  if (w_tick) w_state_nxt = STOP;
`else
            DATA:    if (w_last) w_state_nxt = STOP;
`endif
            STOP:    if (w_tick) w_state_nxt = w_rx_s ? IDLE : BREAK;
            BREAK:   if (w_rx_s) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A bad stop bit overrides a parity mismatch, so at most one strobe fires.
    always_comb begin
        w_fe_set = w_stop_smp && !w_rx_s;
`ifdef UART_RX_DESER_PARITY_EN
        w_pe_set = w_stop_smp && w_rx_s && r_par_bad;
`else
        w_pe_set = 1'b0;
`endif
        w_dv_set = w_stop_smp && w_rx_s && !w_pe_set;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_sync     <= 2'b11;
            r_rx_d     <= 1'b1;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_DESER_PARITY_EN
            r_par_bad  <= 1'b0;
`endif
        end else begin
            r_sync     <= {r_sync[0], RX};
            r_rx_d     <= w_rx_s;
            r_cnt      <= (r_state == IDLE || w_state_nxt != r_state || w_tick) ? '0 : r_cnt + 1'b1;
            r_bit      <= r_state != DATA ? '0 : w_tick ? r_bit + 1'b1 : r_bit;
            if (r_state == DATA && w_tick) r_shift <= {w_rx_s, r_shift[WIDTH-1:1]};
            if (w_dv_set) data <= r_shift;
            data_valid <= w_dv_set;
            frame_err  <= w_fe_set;
            parity_err <= w_pe_set;
`ifdef UART_RX_DESER_PARITY_EN
            if (r_state == PARITY && w_tick) r_par_bad <= ^r_shift ^ w_rx_s;
`endif
        end
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: frame-level scoreboard for uart_rx_deser at CPB=10, checked every cycle.
module tb_uart_rx_deser;
    localparam int CPB  = 10;
    localparam int HALF = 5;
    localparam int W    = 8;
`ifdef UART_RX_DESER_PARITY_EN
    localparam int PARB = 1;
`else
    localparam int PARB = 0;
`endif
    // RX change -> strobe: 2 sync cycles, half bit, WIDTH data + stop (+parity), 1 register
    localparam int LAT      = 2 + HALF + (W + 1 + PARB) * CPB + 1;
    localparam int PINLAT   = PARB ? 108 : 98;
    localparam int PINFRAME = PARB ? 110 : 100;
    localparam logic [2:0] K_DV = 3'b100, K_FE = 3'b010, K_PE = 3'b001;

    typedef struct {logic [2:0] k; logic [7:0] d; int c;} ev_t;
    typedef struct {int a; int b;} win_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX  = 1'b1;
    logic [7:0] data;
    logic       data_valid, frame_err, parity_err, busy;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   fe_n = 0;
    int   pe_n = 0;
    int   dv_cyc[$];
    ev_t  q[$];
    win_t win[$];
    logic [7:0] exp_data = '0;
    logic [2:0] exp_stb;
    logic       exp_busy;

    uart_rx_deser #(.CLK_FREQ(1200000), .BAUD(115200), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .RX(RX), .data(data), .data_valid(data_valid),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
        end
    endtask

    function automatic int dv_at(input int i);
        return i < dv_cyc.size() ? dv_cyc[i] : -100000;
    endfunction

    always @(negedge clk) begin
        if (!rst) exp_data = '0;
        exp_stb = 3'b000;
        if (q.size() > 0 && q[0].c == cyc) begin
            exp_stb = q[0].k;
            if (q[0].k == K_DV) exp_data = q[0].d;
            void'(q.pop_front());
        end
        exp_busy = 1'b0;
        foreach (win[i]) if (cyc >= win[i].a && cyc < win[i].b) exp_busy = 1'b1;
        chk("strobes", {29'd0, data_valid, frame_err, parity_err}, {29'd0, exp_stb});
        chk("data", {24'd0, data}, {24'd0, exp_data});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        if (data_valid) dv_cyc.push_back(cyc);
        if (frame_err) fe_n++;
        if (parity_err) pe_n++;
    end

    task automatic drive_bit(input logic b);
        RX = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pushes the expected outcome; framing-error callers add their own busy window.
    task automatic send(input logic [7:0] d, input logic stop_b, input logic par_b, output int s);
        logic [2:0] k;
        s = cyc;
        k = !stop_b ? K_FE : (PARB != 0 && (^d ^ par_b)) ? K_PE : K_DV;
        q.push_back('{k, d, s + LAT});
        if (stop_b) win.push_back('{s + 3, s + LAT});
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) drive_bit(d[i]);
        if (PARB != 0) drive_bit(par_b);
        drive_bit(stop_b);
    endtask

    initial begin
        int s1, s2, s;
        logic [7:0] b7e;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(5);
        send(8'h55, 1'b1, 1'b0, s1);
        idle(20);
        send(8'hA3, 1'b1, 1'b0, s2);
        idle(5);
        chk("t1_latency", dv_at(0) - s1, PINLAT);
        chk("t1_latency2", dv_at(1) - s2, PINLAT);
        send(8'h00, 1'b1, 1'b0, s);
        send(8'hFF, 1'b1, 1'b0, s);
        idle(5);
        chk("t2_spacing", dv_at(3) - dv_at(2), PINFRAME);
        chk("t2_data", {24'd0, data}, 32'hFF);
        chk("t2_no_fe", fe_n, 0);
        idle(10);
        win.push_back('{cyc + 3, cyc + 8});
        RX = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(20);
        chk("t3_no_dv", dv_cyc.size(), 4);
        win.push_back('{cyc + 3, cyc + PINFRAME + 53});
        send(8'h3C, 1'b0, 1'b0, s);
        repeat (50) @(posedge clk);
        #1;
        idle(20);
        chk("t4_fe_count", fe_n, 1);
        chk("t4_data_kept", {24'd0, data}, 32'hFF);
        send(8'h11, 1'b1, 1'b0, s);
        idle(5);
        chk("t4_data", {24'd0, data}, 32'h11);
        win.push_back('{cyc + 3, cyc + 45});
        b7e = 8'h7E;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b7e[i]);
        RX = b7e[3];
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        RX = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_reset_data", {24'd0, data}, 32'h0);
        rst = 1'b1;
        idle(20);
        chk("t5_no_dv", dv_cyc.size(), 5);
        send(8'h81, 1'b1, 1'b0, s);
        idle(5);
        chk("t5_data", {24'd0, data}, 32'h81);
        chk("t5_dv_count", dv_cyc.size(), 6);
`ifdef UART_RX_DESER_PARITY_EN
        send(8'h07, 1'b1, 1'b1, s);
        idle(5);
        chk("t6_good_data", {24'd0, data}, 32'h07);
        send(8'h07, 1'b1, 1'b0, s);
        idle(5);
        chk("t6_pe_count", pe_n, 1);
        chk("t6_dv_count", dv_cyc.size(), 7);
`endif
        idle(30);
        chk("queue_drained", q.size(), 0);
        chk("no_parity_err", pe_n, PARB);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
